// File: rtl/irq_client_n.sv
// irq_client_n: machine-mode trap sequencer for NUM_IRQ level interrupts plus ECALL/MRET.
//
// Ports:
//   clk, clr                  clock and synchronous active-high reset
//   irq_pins[NUM_IRQ]         level interrupt requests, held until int_ack
//   instr_ID, instr_addr_ID   instruction in ID and its PC
//   branch_EX, branch_addr_EX taken redirect resolved in EX
//   mtvec, mepc, mstatus, mie current CSR values
//   set_pl_pause              combinational pipeline freeze
//   csr_we/csr_waddr/csr_wdata registered CSR client write port
//   int_flag, int_addr        registered one-cycle fetch redirect
//   int_ack[NUM_IRQ]          registered one-hot acknowledge
//
// Build option: define IRQ_ROUND_ROBIN_EN for round-robin arbitration of the
// interrupt lines; otherwise the lowest pending line always wins.
module irq_client_n #(
    parameter int NUM_IRQ        = 4,
    parameter int IRQ_CAUSE_BASE = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_IRQ-1:0] irq_pins,
    input  logic [31:0]        instr_ID,
    input  logic [31:0]        instr_addr_ID,
    input  logic               branch_EX,
    input  logic [31:0]        branch_addr_EX,
    input  logic [31:0]        mtvec,
    input  logic [31:0]        mepc,
    input  logic [31:0]        mstatus,
    input  logic [31:0]        mie,
    output logic               set_pl_pause,
    output logic               csr_we,
    output logic [11:0]        csr_waddr,
    output logic [31:0]        csr_wdata,
    output logic               int_flag,
    output logic [31:0]        int_addr,
    output logic [NUM_IRQ-1:0] int_ack
);
    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] MRET_I = 32'h30200073;

    typedef enum logic [2:0] {IDLE, MEPC, MSTATUS, MCAUSE, MRET} state_t;

    state_t             state;
    logic [31:0]        epc;
    logic [31:0]        cause;
    logic [NUM_IRQ-1:0] pending;
    logic [IW-1:0]      idx;
    logic               async_req, busy, take;
    logic               take_ecall, take_mret, take_async;
    logic [31:0]        mst_trap, mst_ret;
    logic               unused_mie;

    assign unused_mie = ^mie;
    assign pending    = irq_pins & mie[NUM_IRQ-1:0];
    assign async_req  = mstatus[3] & |pending;
    assign busy       = (state != IDLE) | csr_we | int_flag;
    assign take_ecall = !busy & (instr_ID == ECALL);
    assign take_mret  = !busy & (instr_ID == MRET_I);
    assign take_async = !busy & !(instr_ID == ECALL) & !(instr_ID == MRET_I) & async_req;
    assign take       = take_ecall | take_mret | take_async;
    assign set_pl_pause = take | busy;

    // Trap entry saves MIE into MPIE and disables; return restores MIE from MPIE and sets MPIE.
    assign mst_trap = {mstatus[31:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]};
    assign mst_ret  = {mstatus[31:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]};

`ifdef IRQ_ROUND_ROBIN_EN
    // ptr is the index the search starts from; it moves past each serviced line.
    logic [IW-1:0] ptr;
    logic          found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (!found && pending[(int'(ptr) + k) % NUM_IRQ]) begin
                idx   = IW'((int'(ptr) + k) % NUM_IRQ);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr)
            ptr <= '0;
        else if (take_async)
            ptr <= (idx == IW'(NUM_IRQ - 1)) ? '0 : idx + 1'b1;
    end
`else
    always_comb begin
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pending[i]) idx = IW'(i);
    end
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            epc       <= '0;
            cause     <= '0;
            csr_we    <= 1'b0;
            csr_waddr <= '0;
            csr_wdata <= '0;
            int_flag  <= 1'b0;
            int_addr  <= '0;
            int_ack   <= '0;
        end else begin
            csr_we    <= (state == MEPC) | (state == MSTATUS) | (state == MCAUSE) | (state == MRET);
            csr_waddr <= (state == MEPC)   ? 12'h341 :
                         (state == MCAUSE) ? 12'h342 :
                         (state == MSTATUS || state == MRET) ? 12'h300 : 12'h000;
            csr_wdata <= (state == MEPC)    ? epc :
                         (state == MSTATUS) ? mst_trap :
                         (state == MCAUSE)  ? cause :
                         (state == MRET)    ? mst_ret : 32'h0;
            int_flag  <= (state == MCAUSE) | (state == MRET);
            int_addr  <= (state == MCAUSE) ? mtvec : (state == MRET) ? mepc : 32'h0;
            int_ack   <= take_async ? (NUM_IRQ'(1) << idx) : '0;
            if (take_ecall) begin
                epc   <= instr_addr_ID;
                cause <= 32'd11;
            end else if (take_async) begin
                epc   <= branch_EX ? branch_addr_EX : instr_addr_ID;
                cause <= {1'b1, 31'(IRQ_CAUSE_BASE + int'(idx))};
            end
            state <= (state == IDLE)    ? (take_mret ? MRET : (take_ecall | take_async) ? MEPC : IDLE) :
                     (state == MEPC)    ? MSTATUS :
                     (state == MSTATUS) ? MCAUSE : IDLE;
        end
    end
endmodule

// File: tb/tb_irq_client_n.sv
// tb_irq_client_n: directed table-driven bench for irq_client_n.
module tb_irq_client_n;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] MRETI = 32'h30200073;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  irq_pins = '0;
    logic [31:0] instr_ID = NOP;
    logic [31:0] instr_addr_ID = '0;
    logic        branch_EX = 1'b0;
    logic [31:0] branch_addr_EX = '0;
    logic [31:0] mtvec = '0, mepc = '0, mstatus = '0, mie = '0;
    logic        set_pl_pause, csr_we, int_flag;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, int_addr;
    logic [3:0]  int_ack;

    int checks = 0;
    int errors = 0;

    irq_client_n #(.NUM_IRQ(4), .IRQ_CAUSE_BASE(16)) dut (
        .clk(clk), .clr(clr), .irq_pins(irq_pins), .instr_ID(instr_ID),
        .instr_addr_ID(instr_addr_ID), .branch_EX(branch_EX), .branch_addr_EX(branch_addr_EX),
        .mtvec(mtvec), .mepc(mepc), .mstatus(mstatus), .mie(mie),
        .set_pl_pause(set_pl_pause), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .int_flag(int_flag), .int_addr(int_addr), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  irq;
        logic [31:0] instr, pc;
        logic        br;
        logic [31:0] baddr, tvec, epc_in, mst, mie_v;
        int          kind;   // 0 no request, 1 trap, 2 return
        logic [3:0]  ack;
        logic [31:0] x_epc, x_mst, x_cause, x_addr;
    } vec_t;

    vec_t v[10];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_write(input string nm, input logic [11:0] a, input logic [31:0] d);
        chk({nm, " we"}, 32'(csr_we), 32'd1);
        chk({nm, " waddr"}, 32'(csr_waddr), 32'(a));
        chk({nm, " wdata"}, csr_wdata, d);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " we"}, 32'(csr_we), 32'd0);
        chk({nm, " waddr"}, 32'(csr_waddr), 32'd0);
        chk({nm, " wdata"}, csr_wdata, 32'd0);
        chk({nm, " flag"}, 32'(int_flag), 32'd0);
        chk({nm, " addr"}, int_addr, 32'd0);
    endtask

    logic [3:0] rr_exp [3];

    initial begin
        v[0] = '{4'b0000, ECALL, 32'h100, 1'b0, 32'h0, 32'h80, 32'h0, 32'h8, 32'h0, 1, 4'b0000, 32'h100, 32'h80, 32'd11, 32'h80};
        v[1] = '{4'b0000, MRETI, 32'h0, 1'b0, 32'h0, 32'h80, 32'h104, 32'h80, 32'h0, 2, 4'b0000, 32'h0, 32'h88, 32'h0, 32'h104};
        v[2] = '{4'b0110, NOP, 32'h300, 1'b1, 32'h200, 32'h80, 32'h0, 32'h8, 32'hF, 1, 4'b0010, 32'h200, 32'h80, 32'h80000011, 32'h80};
        v[3] = '{4'b1111, NOP, 32'h300, 1'b0, 32'h0, 32'h80, 32'h0, 32'h8, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
        v[4] = '{4'b1111, NOP, 32'h300, 1'b0, 32'h0, 32'h80, 32'h0, 32'h0, 32'hF, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
        v[5] = '{4'b0001, ECALL, 32'h40, 1'b0, 32'h0, 32'h80, 32'h0, 32'h8, 32'hF, 1, 4'b0000, 32'h40, 32'h80, 32'd11, 32'h80};
        v[6] = '{4'b1000, NOP, 32'h500, 1'b0, 32'h0, 32'h1000, 32'h0, 32'h88, 32'hF, 1, 4'b1000, 32'h500, 32'h80, 32'h80000013, 32'h1000};
        v[7] = '{4'b1100, NOP, 32'h600, 1'b0, 32'h0, 32'h2000, 32'h0, 32'h1808, 32'h8, 1, 4'b1000, 32'h600, 32'h1880, 32'h80000013, 32'h2000};
        v[8] = '{4'b0000, MRETI, 32'h0, 1'b0, 32'h0, 32'h80, 32'h44, 32'h0, 32'h0, 2, 4'b0000, 32'h0, 32'h80, 32'h0, 32'h44};
        v[9] = '{4'b0001, MRETI, 32'h0, 1'b0, 32'h0, 32'h80, 32'h48, 32'h8, 32'hF, 2, 4'b0000, 32'h0, 32'h80, 32'h0, 32'h48};

        // reset state
        step;
        step;
        chk_quiet("reset");
        chk("reset ack", 32'(int_ack), 32'd0);
        chk("reset pause", 32'(set_pl_pause), 32'd0);
        clr = 1'b0;
        step;

        for (int n = 0; n < 10; n++) begin
            irq_pins = v[n].irq; instr_ID = v[n].instr; instr_addr_ID = v[n].pc;
            branch_EX = v[n].br; branch_addr_EX = v[n].baddr; mtvec = v[n].tvec;
            mepc = v[n].epc_in; mstatus = v[n].mst; mie = v[n].mie_v;
            #1;
            chk($sformatf("v%0d c0 pause", n), 32'(set_pl_pause), 32'(v[n].kind != 0));
            step;
            chk($sformatf("v%0d c1 ack", n), 32'(int_ack), 32'(v[n].ack));
            chk($sformatf("v%0d c1 we", n), 32'(csr_we), 32'd0);
            chk($sformatf("v%0d c1 pause", n), 32'(set_pl_pause), 32'(v[n].kind != 0));
            irq_pins = '0; instr_ID = NOP; branch_EX = 1'b0;
            if (v[n].kind == 1) begin
                step;
                chk_write($sformatf("v%0d mepc", n), 12'h341, v[n].x_epc);
                chk($sformatf("v%0d c2 flag", n), 32'(int_flag), 32'd0);
                chk($sformatf("v%0d c2 ack", n), 32'(int_ack), 32'd0);
                step;
                chk_write($sformatf("v%0d mstatus", n), 12'h300, v[n].x_mst);
                step;
                chk_write($sformatf("v%0d mcause", n), 12'h342, v[n].x_cause);
                chk($sformatf("v%0d c4 flag", n), 32'(int_flag), 32'd1);
                chk($sformatf("v%0d c4 addr", n), int_addr, v[n].x_addr);
                chk($sformatf("v%0d c4 pause", n), 32'(set_pl_pause), 32'd1);
                step;
                chk_quiet($sformatf("v%0d c5", n));
                chk($sformatf("v%0d c5 pause", n), 32'(set_pl_pause), 32'd0);
            end else if (v[n].kind == 2) begin
                step;
                chk_write($sformatf("v%0d mret", n), 12'h300, v[n].x_mst);
                chk($sformatf("v%0d c2 flag", n), 32'(int_flag), 32'd1);
                chk($sformatf("v%0d c2 addr", n), int_addr, v[n].x_addr);
                chk($sformatf("v%0d c2 pause", n), 32'(set_pl_pause), 32'd1);
                step;
                chk_quiet($sformatf("v%0d c3", n));
                chk($sformatf("v%0d c3 pause", n), 32'(set_pl_pause), 32'd0);
            end else begin
                chk_quiet($sformatf("v%0d c1", n));
            end
            step;
        end

        // lines 0 and 2 held; each trap clears MIE and an MRET re-enables it
`ifdef IRQ_ROUND_ROBIN_EN
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b0001;
`else
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0001; rr_exp[2] = 4'b0001;
`endif
        irq_pins = 4'b0101; mie = 32'hF; mstatus = 32'h8; mtvec = 32'h80; mepc = 32'h900;
        for (int it = 0; it < 3; it++) begin
            #1;
            chk($sformatf("arb%0d pause", it), 32'(set_pl_pause), 32'd1);
            step;
            chk($sformatf("arb%0d ack", it), 32'(int_ack), 32'(rr_exp[it]));
            mstatus = 32'h80;
            step; step; step; step;
            chk($sformatf("arb%0d idle pause", it), 32'(set_pl_pause), 32'd0);
            chk($sformatf("arb%0d no reack", it), 32'(int_ack), 32'd0);
            instr_ID = MRETI;
            step;
            instr_ID = NOP;
            step;
            chk_write($sformatf("arb%0d mret", it), 12'h300, 32'h88);
            mstatus = 32'h8;
            step;
        end
        irq_pins = '0;
        mstatus = 32'h0;
        step; step; step; step; step; step;

        // reset asserted in cycle 2 of an ECALL trap
        mstatus = 32'h8; mtvec = 32'h80; instr_addr_ID = 32'h100; instr_ID = ECALL;
        #1;
        chk("rst c0 pause", 32'(set_pl_pause), 32'd1);
        step;
        instr_ID = NOP;
        step;
        chk_write("rst c2 mepc", 12'h341, 32'h100);
        clr = 1'b1;
        step;
        clr = 1'b0;
        chk_quiet("rst c3");
        chk("rst c3 ack", 32'(int_ack), 32'd0);
        chk("rst c3 pause", 32'(set_pl_pause), 32'd0);
        step;
        chk_quiet("rst c4");
        step;
        chk_quiet("rst c5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_client_n.md
# irq_client_n

Parametrised machine-mode trap sequencer, successor to the single-timer interrupt client. It arbitrates `NUM_IRQ` maskable level-sensitive interrupt lines plus ECALL/MRET seen in ID. It stalls the pipeline, writes MEPC/MSTATUS/MCAUSE through the CSR client port one register per cycle, then redirects fetch to `mtvec` (trap) or `mepc` (return). It sits between the ID/EX pipeline stages and the CSR file's client write port.

## Interface
- `NUM_IRQ`, 4: number of external interrupt lines, legal range 1..16.
- `IRQ_CAUSE_BASE`, 16: async cause code of line 0; line i reports `{1'b1, 31'(IRQ_CAUSE_BASE+i)}`.
- `clk` in 1: single clock; all state updates on rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `irq_pins` in NUM_IRQ: level interrupt requests, held by source until `int_ack`.
- `instr_ID` in 32: instruction in ID.
- `instr_addr_ID` in 32: PC of `instr_ID`.
- `branch_EX` in 1 / `branch_addr_EX` in 32: taken redirect resolved in EX.
- `mtvec`, `mepc`, `mstatus`, `mie` in 32 each: current CSR values.
- `set_pl_pause` out 1: combinational pipeline freeze.
- `csr_we` out 1, `csr_waddr` out 12, `csr_wdata` out 32: registered CSR client write port.
- `int_flag` out 1, `int_addr` out 32: registered one-cycle fetch redirect.
- `int_ack` out NUM_IRQ: registered one-hot acknowledge to the serviced line.

## Operation
- `pending = irq_pins & mie[NUM_IRQ-1:0]`; `async_req = mstatus[3] & |pending`.
- `busy = (state != IDLE) | csr_we | int_flag`. No request is taken while `busy`.
- In IDLE and not busy, priority is: ECALL (`32'h00000073`) > MRET (`32'h30200073`) > async_req. The winner is `take`.
- On `take` the block latches:
  - ECALL: epc = `instr_addr_ID`, cause = 11.
  - Async: epc = `branch_EX ? branch_addr_EX : instr_addr_ID`, cause from the winning line index, and `int_ack[idx]` is pulsed.
- Winning line: lowest set bit of `pending` (fixed priority, default build).
- FSM states: IDLE, MEPC, MSTATUS, MCAUSE, MRET.
  - Trap path: IDLE→MEPC→MSTATUS→MCAUSE→IDLE.
  - MRET path: IDLE→MRET→IDLE.
  - Any other state→IDLE.
- Writes are registered from the current state:
  - MEPC: addr 0x341, data epc.
  - MSTATUS: addr 0x300, data = mstatus with bit7 (MPIE) ← mstatus[3] and bit3 (MIE) ← 0.
  - MCAUSE: addr 0x342, data cause.
  - MRET: addr 0x300, data = mstatus with bit3 ← mstatus[7] and bit7 ← 1.
  - In all other states `csr_we`, `csr_waddr` and `csr_wdata` are 0.
- `int_flag`/`int_addr` are registered:
  - From MCAUSE: 1 / `mtvec`.
  - From MRET: 1 / `mepc`.
  - Otherwise: 0 / 0.
- `set_pl_pause = take | busy`.
- Reset: state IDLE; latches, `csr_we`, `csr_waddr`, `csr_wdata`, `int_flag`, `int_addr` and `int_ack` are all 0 after the edge. `clr` asserted mid-sequence abandons it with no further CSR writes.
- A line dropped after `take` does not alter the sequence in progress.
- The lowest line is serviced first; others stay pending.

## Timing
- Request present in cycle 0: `set_pl_pause`=1 combinationally in cycle 0.
- Trap path:
  - Cycle 1: state MEPC; `int_ack` pulses in cycle 1 (async only).
  - Cycle 2: MEPC write.
  - Cycle 3: MSTATUS write.
  - Cycle 4: MCAUSE write together with `int_flag`=1, `int_addr`=mtvec.
  - Pause holds cycles 0–4. Earliest next `take` is cycle 5.
- MRET path:
  - Cycle 1: state MRET.
  - Cycle 2: MSTATUS write together with `int_flag`=1, `int_addr`=mepc.
  - Pause holds cycles 0–2.
- ECALL and async in the same cycle: ECALL is taken and the async request stays pending. The async trap is taken later only if MIE is re-enabled.

## Configuration
- `IRQ_ROUND_ROBIN_EN`:
  - Defined: async arbitration is round-robin. A registered pointer (reset 0) sets search start at `last_idx+1` modulo NUM_IRQ. The pointer updates only on an async `take`.
  - Undefined: fixed priority, lowest index wins, no pointer register.

## Test plan
- Reset mid-trap: `clr` high in cycle 2 of a trap → no MSTATUS or MCAUSE write, `int_flag` stays 0, all outputs 0 afterwards.
- ECALL at PC 0x100, mtvec=0x80, mstatus=0x8:
  - Writes (0x341, 0x100), then (0x300, 0x80), then (0x342, 11).
  - `int_flag`=1 with `int_addr`=0x80 in cycle 4.
  - Pause high in cycles 0–4.
- MRET with mepc=0x104, mstatus=0x80 → write (0x300, 0x88); `int_flag`=1, `int_addr`=0x104 in cycle 2.
- `irq_pins`=4'b0110, mie=0xF, mstatus[3]=1, `branch_EX`=1 to 0x200:
  - `int_ack`=4'b0010.
  - MEPC data 0x200.
  - MCAUSE 0x80000011.
- `irq_pins`=4'b1111 with mie=0 or mstatus[3]=0 → no pause, no write. ECALL together with irq → cause 11.
- `IRQ_ROUND_ROBIN_EN` build with lines 0 and 2 held high, MIE re-set by MRET each time → acks alternate 4'b0001, 4'b0100, 4'b0001.
